sad_accum_pipe: RTL and testbench

SAD_ACCUM_PIPE -- requirements
Module: sad_accum_pipe

---
 rtl/sad_accum_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_sad_accum_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_accum_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sad_accum_pipe                                               |
// | Description : Pipelined sum-of-absolute-differences accumulator for block  |
// |               motion search. Each beat carries LANES pixel pairs; the      |
// |               per-lane |cur-can| values are registered, reduced through a  |
// |               registered pairwise adder tree, accumulated per candidate    |
// |               block, and reported with the block index and a beat-count    |
// |               error flag. Optional running-minimum tracker.                |
// | Macro       : SAD_MIN_TRACK_EN - enables the best-match tracker (best_*,   |
// |               clr). Undefined: best_* are tied to reset values.            |
// | Ports       : clk, rst_n (sync, active-low)                                |
// |               in_valid/in_first/in_last, cur_pix, can_pix, cand_idx - beat |
// |               clr - restart best-match search                              |
// |               out_valid/out_sad/out_idx/out_err - completed block result   |
// |               best_valid/best_sad/best_idx - running best match            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sad_accum_pipe #(
    parameter int PIX_W = 8,
    parameter int LANES = 16,
    parameter int BEATS = 16,
    parameter int IDX_W = 8,
    localparam int SAD_W = PIX_W + $clog2(LANES * BEATS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [LANES*PIX_W-1:0] cur_pix,
    input  logic [LANES*PIX_W-1:0] can_pix,
    input  logic [IDX_W-1:0]       cand_idx,
    input  logic                   clr,
    output logic                   out_valid,
    output logic [SAD_W-1:0]       out_sad,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_err,
    output logic                   best_valid,
    output logic [SAD_W-1:0]       best_sad,
    output logic [IDX_W-1:0]       best_idx
);

    localparam int LOG2  = $clog2(LANES);
    localparam int SUM_W = PIX_W + LOG2;
    // Wide enough to hold BEATS+1, so an over-long block never wraps back to BEATS.
    localparam int CNT_W = $clog2(BEATS + 2);
    localparam logic [CNT_W-1:0] c_beats_cnt = CNT_W'(BEATS);

    // Stage 1: per-lane absolute difference.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PIX_W-1:0] w_cur;
        logic [PIX_W-1:0] w_can;
        logic [PIX_W-1:0] r_absd;
        assign w_cur = cur_pix[i*PIX_W +: PIX_W];
        assign w_can = can_pix[i*PIX_W +: PIX_W];
        always_ff @(posedge clk) begin
            r_absd <= (w_cur >= w_can) ? (w_cur - w_can) : (w_can - w_cur);
        end
    end

    // Adder tree: level k holds LANES>>k partial sums, each PIX_W+k bits wide.
    for (genvar k = 1; k <= LOG2; k++) begin : g_lvl
        for (genvar j = 0; j < (LANES >> k); j++) begin : g_node
            logic [PIX_W+k-1:0] r_sum;
            if (k == 1) begin : g_leaf
                always_ff @(posedge clk) begin
                    r_sum <= {1'b0, g_lane[2*j].r_absd} + {1'b0, g_lane[2*j+1].r_absd};
                end
            end else begin : g_inner
                always_ff @(posedge clk) begin
                    r_sum <= {1'b0, g_lvl[k-1].g_node[2*j].r_sum}
                           + {1'b0, g_lvl[k-1].g_node[2*j+1].r_sum};
                end
            end
        end
    end

    logic [SUM_W-1:0] w_beat_sum;
    assign w_beat_sum = g_lvl[LOG2].g_node[0].r_sum;

    // Sideband travels with the data: index 0 = stage 1, index LOG2 = tree output.
    logic [LOG2:0]    r_v;
    logic [LOG2:0]    r_f;
    logic [LOG2:0]    r_l;
    logic [IDX_W-1:0] r_sb_idx [LOG2+1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v <= '0;
        end else begin
            r_v <= {r_v[LOG2-1:0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        r_f         <= {r_f[LOG2-1:0], in_first};
        r_l         <= {r_l[LOG2-1:0], in_last};
        r_sb_idx[0] <= cand_idx;
        for (int k = 1; k <= LOG2; k++) begin
            r_sb_idx[k] <= r_sb_idx[k-1];
        end
    end

    // Accumulator stage.
    logic             w_tv;
    logic             w_tf;
    logic             w_tl;
    logic             w_take;
    logic [SAD_W:0]   w_add;
    logic [SAD_W-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_open;
    logic             r_done;
    logic [SAD_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_blk_idx;

    assign w_tv = r_v[LOG2];
    assign w_tf = r_f[LOG2];
    assign w_tl = r_l[LOG2];
    // A first beat always opens a block (abandoning any open one); other beats
    // only count while a block is open, so strays after a last beat are dropped.
    assign w_take     = w_tv & (w_tf | r_open);
    assign w_add      = {1'b0, r_acc} + (SAD_W+1)'(w_beat_sum);
    assign w_acc_next = w_tf ? SAD_W'(w_beat_sum)
                             : (w_add[SAD_W] ? {SAD_W{1'b1}} : w_add[SAD_W-1:0]);
    assign w_cnt_next = w_tf ? CNT_W'(1)
                             : ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_open    <= 1'b0;
            r_done    <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_blk_idx <= '0;
        end else begin
            r_done <= w_take & w_tl;
            if (w_take) begin
                r_acc  <= w_acc_next;
                r_cnt  <= w_cnt_next;
                r_open <= ~w_tl;
                if (w_tf) begin
                    r_blk_idx <= r_sb_idx[LOG2];
                end
            end
        end
    end

    // Output stage: results hold until the next completed block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sad   <= '0;
            out_idx   <= '0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= r_done;
            if (r_done) begin
                out_sad <= r_acc;
                out_idx <= r_blk_idx;
                out_err <= (r_cnt != c_beats_cnt);
            end
        end
    end

`ifdef SAD_MIN_TRACK_EN
    logic w_res_ok;
    assign w_res_ok = out_valid & ~out_err;

    // A result coinciding with clr seeds the new search instead of being lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_valid <= 1'b0;
            best_sad   <= {SAD_W{1'b1}};
            best_idx   <= '0;
        end else if (clr) begin
            if (w_res_ok) begin
                best_valid <= 1'b1;
                best_sad   <= out_sad;
                best_idx   <= out_idx;
            end else begin
                best_valid <= 1'b0;
                best_sad   <= {SAD_W{1'b1}};
            end
        end else if (w_res_ok && (out_sad < best_sad)) begin
            best_valid <= 1'b1;
            best_sad   <= out_sad;
            best_idx   <= out_idx;
        end
    end
`else
    logic w_unused_clr;
    assign w_unused_clr = clr;
    assign best_valid   = 1'b0;
    assign best_sad     = {SAD_W{1'b1}};
    assign best_idx     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sad_accum_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sad_accum_pipe                                            |
// | Description : Self-checking bench for sad_accum_pipe. A behavioural block  |
// |               model pushes expected results (with expected output cycle)   |
// |               into a queue as beats are driven; a monitor pops and         |
// |               compares on every out_valid. Scenario tasks check the rest.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sad_accum_pipe;

    localparam int PIX_W   = 8;
    localparam int LANES   = 16;
    localparam int BEATS   = 16;
    localparam int IDX_W   = 8;
    localparam int SAD_W   = 16;
    localparam int LAT     = 6;
    localparam int SAD_MAX = 65535;
    localparam int DW      = LANES * PIX_W;
`ifdef SAD_MIN_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_first = 1'b0;
    logic             in_last = 1'b0;
    logic [DW-1:0]    cur_pix = '0;
    logic [DW-1:0]    can_pix = '0;
    logic [IDX_W-1:0] cand_idx = '0;
    logic             clr = 1'b0;
    logic             out_valid;
    logic [SAD_W-1:0] out_sad;
    logic [IDX_W-1:0] out_idx;
    logic             out_err;
    logic             best_valid;
    logic [SAD_W-1:0] best_sad;
    logic [IDX_W-1:0] best_idx;

    sad_accum_pipe #(
        .PIX_W(PIX_W), .LANES(LANES), .BEATS(BEATS), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .cur_pix(cur_pix), .can_pix(can_pix),
        .cand_idx(cand_idx), .clr(clr), .out_valid(out_valid),
        .out_sad(out_sad), .out_idx(out_idx), .out_err(out_err),
        .best_valid(best_valid), .best_sad(best_sad), .best_idx(best_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [IDX_W-1:0] idx;
        logic             err;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pulse = 0;

    // Behavioural block model state.
    bit               m_open = 1'b0;
    int               m_acc = 0;
    int               m_cnt = 0;
    logic [IDX_W-1:0] m_idx = '0;

    logic [SAD_W-1:0] held_sad = '0;
    logic [IDX_W-1:0] held_idx = '0;
    logic             held_err = 1'b0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            held_sad = '0;
            held_idx = '0;
            held_err = 1'b0;
        end else if (out_valid) begin
            n_pulse++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out_valid: got sad=%0d idx=%0d, required no pulse", out_sad, out_idx);
            end else begin
                e = sb.pop_front();
                if (out_sad !== e.sad || out_idx !== e.idx || out_err !== e.err || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL result: got sad=%0d idx=%0d err=%0b cyc=%0d, required sad=%0d idx=%0d err=%0b cyc=%0d",
                             out_sad, out_idx, out_err, cyc, e.sad, e.idx, e.err, e.cyc);
                end
            end
            held_sad = out_sad;
            held_idx = out_idx;
            held_err = out_err;
        end else begin
            n_cmp++;
            if (out_sad !== held_sad || out_idx !== held_idx || out_err !== held_err) begin
                n_bad++;
                $display("FAIL hold: got sad=%0d idx=%0d err=%0b, required sad=%0d idx=%0d err=%0b",
                         out_sad, out_idx, out_err, held_sad, held_idx, held_err);
            end
        end
    end

    function automatic logic [DW-1:0] rnd();
        rnd = {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic beat(input bit v, input bit f, input bit l,
                        input logic [DW-1:0] c, input logic [DW-1:0] d,
                        input logic [IDX_W-1:0] ix);
        int   bs;
        int   a;
        int   b;
        bit   took;
        exp_t e;
        in_valid = v; in_first = f; in_last = l;
        cur_pix = c; can_pix = d; cand_idx = ix;
        @(posedge clk); #1;
        if (!rst_n) begin
            m_open = 1'b0;
        end else if (v) begin
            bs = 0;
            for (int i = 0; i < LANES; i++) begin
                a = int'(c[i*PIX_W +: PIX_W]);
                b = int'(d[i*PIX_W +: PIX_W]);
                bs += (a > b) ? (a - b) : (b - a);
            end
            took = f || m_open;
            if (f) begin
                m_open = 1'b1; m_acc = bs; m_cnt = 1; m_idx = ix;
            end else if (m_open) begin
                m_acc = (m_acc + bs > SAD_MAX) ? SAD_MAX : m_acc + bs;
                m_cnt++;
            end
            if (took && l) begin
                e.sad = m_acc[SAD_W-1:0];
                e.idx = m_idx;
                e.err = (m_cnt != BEATS);
                e.cyc = cyc + LAT;
                sb.push_back(e);
                m_open = 1'b0;
            end
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Block whose SAD equals `sad`, carried in lane 0; other lanes match.
    task automatic send_block(input logic [IDX_W-1:0] ix, input int sad, input int gap);
        int            rem;
        int            dv;
        logic [DW-1:0] c;
        logic [DW-1:0] d;
        rem = sad;
        for (int b = 0; b < BEATS; b++) begin
            c = rnd(); d = c;
            dv = (rem > 255) ? 255 : rem;
            rem -= dv;
            c[7:0] = 8'h00;
            d[7:0] = dv[7:0];
            beat(1'b1, b == 0, b == BEATS - 1, c, d, ix);
            if (gap > 0 && b < BEATS - 1) idle(gap);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            idle(1);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        idle(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        n_cmp += 7;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b, required 0", out_valid); end
        if (out_sad !== '0) begin n_bad++; $display("FAIL rst_out_sad: got %0d, required 0", out_sad); end
        if (out_idx !== '0) begin n_bad++; $display("FAIL rst_out_idx: got %0d, required 0", out_idx); end
        if (out_err !== 1'b0) begin n_bad++; $display("FAIL rst_out_err: got %0b, required 0", out_err); end
        if (best_valid !== 1'b0) begin n_bad++; $display("FAIL rst_best_valid: got %0b, required 0", best_valid); end
        if (best_sad !== 16'hFFFF) begin n_bad++; $display("FAIL rst_best_sad: got %0h, required ffff", best_sad); end
        if (best_idx !== '0) begin n_bad++; $display("FAIL rst_best_idx: got %0d, required 0", best_idx); end
    endtask

    task automatic test_one_beat();
        logic [DW-1:0] c;
        logic [DW-1:0] d;
        c = rnd(); d = c;
        c[5*PIX_W +: PIX_W] = 8'h10;
        d[5*PIX_W +: PIX_W] = 8'h30;
        beat(1'b1, 1'b1, 1'b1, c, d, 8'd7);
        drain();
        n_cmp += 3;
        if (out_sad !== 16'd32 || out_err !== 1'b1) begin
            n_bad++; $display("FAIL one_beat: got sad=%0d err=%0b, required sad=32 err=1", out_sad, out_err);
        end
        if (best_valid !== 1'b0) begin n_bad++; $display("FAIL one_beat_best_valid: got %0b, required 0", best_valid); end
        if (best_sad !== 16'hFFFF) begin n_bad++; $display("FAIL one_beat_best_sad: got %0h, required ffff", best_sad); end
    endtask

    task automatic test_basic();
        int p0;
        p0 = n_pulse;
        for (int b = 0; b < BEATS; b++) beat(1'b1, b == 0, b == BEATS - 1, '0, '1, 8'd3);
        drain();
        n_cmp += 3;
        if (n_pulse - p0 != 1) begin n_bad++; $display("FAIL basic_pulses: got %0d, required 1", n_pulse - p0); end
        if (out_sad !== 16'd65280 || out_idx !== 8'd3 || out_err !== 1'b0) begin
            n_bad++; $display("FAIL basic: got sad=%0d idx=%0d err=%0b, required 65280/3/0", out_sad, out_idx, out_err);
        end
        if (best_sad !== (TRACK ? 16'd65280 : 16'hFFFF) || best_idx !== (TRACK ? 8'd3 : 8'd0) || best_valid !== TRACK) begin
            n_bad++; $display("FAIL basic_best: got sad=%0d idx=%0d valid=%0b, required tracked=%0b", best_sad, best_idx, best_valid, TRACK);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        clr = 1'b1; idle(1); clr = 1'b0;
        p0 = n_pulse;
        send_block(8'd1, 500, 0);
        send_block(8'd2, 300, 0);
        send_block(8'd3, 300, 0);
        drain();
        n_cmp += 2;
        if (n_pulse - p0 != 3) begin n_bad++; $display("FAIL b2b_pulses: got %0d, required 3", n_pulse - p0); end
        if (best_sad !== (TRACK ? 16'd300 : 16'hFFFF) || best_idx !== (TRACK ? 8'd2 : 8'd0) || best_valid !== TRACK) begin
            n_bad++; $display("FAIL b2b_best: got sad=%0d idx=%0d valid=%0b, required %0d/%0d/%0b",
                              best_sad, best_idx, best_valid, TRACK ? 300 : 65535, TRACK ? 2 : 0, TRACK);
        end
    endtask

    task automatic test_bubbles();
        logic [DW-1:0] c;
        for (int b = 0; b < BEATS; b++) begin
            c = rnd();
            beat(1'b1, b == 0, b == BEATS - 1, c, c, 8'd5);
            if (b < BEATS - 1) idle(2);
        end
        drain();
        n_cmp++;
        if (out_sad !== '0 || out_idx !== 8'd5 || out_err !== 1'b0) begin
            n_bad++; $display("FAIL bubbles: got sad=%0d idx=%0d err=%0b, required 0/5/0", out_sad, out_idx, out_err);
        end
    endtask

    task automatic test_protocol();
        int p0;
        p0 = n_pulse;
        // Abandoned block, then a complete one, then strays with no first.
        for (int b = 0; b < 5; b++) beat(1'b1, b == 0, 1'b0, rnd(), rnd(), 8'd10);
        send_block(8'd11, 1234, 0);
        beat(1'b1, 1'b0, 1'b0, rnd(), rnd(), 8'd20);
        beat(1'b1, 1'b0, 1'b1, rnd(), rnd(), 8'd21);
        drain();
        n_cmp++;
        if (n_pulse - p0 != 1 || out_sad !== 16'd1234 || out_idx !== 8'd11) begin
            n_bad++; $display("FAIL abandon: got pulses=%0d sad=%0d idx=%0d, required 1/1234/11", n_pulse - p0, out_sad, out_idx);
        end
        // Short and long random blocks, then a saturating one.
        for (int b = 0; b < 3; b++) beat(1'b1, b == 0, b == 2, rnd(), rnd(), 8'd13);
        for (int b = 0; b < 20; b++) beat(1'b1, b == 0, b == 19, rnd(), rnd(), 8'd14);
        for (int b = 0; b < 17; b++) beat(1'b1, b == 0, b == 16, '0, '1, 8'd12);
        drain();
        n_cmp += 2;
        if (out_sad !== 16'hFFFF || out_err !== 1'b1 || out_idx !== 8'd12) begin
            n_bad++; $display("FAIL saturate: got sad=%0h err=%0b idx=%0d, required ffff/1/12", out_sad, out_err, out_idx);
        end
        if (best_sad !== (TRACK ? 16'd300 : 16'hFFFF)) begin
            n_bad++; $display("FAIL protocol_best: got sad=%0d, required %0d", best_sad, TRACK ? 300 : 65535);
        end
    endtask

    task automatic test_reset_mid();
        int            p0;
        logic [DW-1:0] c;
        p0 = n_pulse;
        for (int b = 0; b < BEATS; b++) begin
            c = rnd();
            if (b == 7) rst_n = 1'b0;
            beat(1'b1, b == 0, b == BEATS - 1, c, ~c, 8'd6);
            rst_n = 1'b1;
        end
        drain();
        n_cmp += 3;
        if (n_pulse != p0) begin n_bad++; $display("FAIL reset_mid_pulses: got %0d, required 0", n_pulse - p0); end
        if (best_sad !== 16'hFFFF) begin n_bad++; $display("FAIL reset_mid_best_sad: got %0h, required ffff", best_sad); end
        if (best_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mid_best_valid: got %0b, required 0", best_valid); end
    endtask

    task automatic test_clr_coincident();
        clr = 1'b1; idle(1); clr = 1'b0;
        send_block(8'd4, 100, 0);
        drain();
        n_cmp++;
        if (best_sad !== (TRACK ? 16'd100 : 16'hFFFF)) begin
            n_bad++; $display("FAIL clr_prior_best: got %0d, required %0d", best_sad, TRACK ? 100 : 65535);
        end
        send_block(8'd9, 700, 0);
        idle(LAT);
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL clr_align: got out_valid=%0b, required 1", out_valid); end
        clr = 1'b1; idle(1); clr = 1'b0;
        drain();
        n_cmp++;
        if (best_sad !== (TRACK ? 16'd700 : 16'hFFFF) || best_idx !== (TRACK ? 8'd9 : 8'd0) || best_valid !== TRACK) begin
            n_bad++; $display("FAIL clr_coincident: got sad=%0d idx=%0d valid=%0b, required %0d/%0d/%0b",
                              best_sad, best_idx, best_valid, TRACK ? 700 : 65535, TRACK ? 9 : 0, TRACK);
        end
    endtask

    initial begin
        test_reset();
        test_one_beat();
        test_basic();
        test_back_to_back();
        test_bubbles();
        test_protocol();
        test_reset_mid();
        test_clr_coincident();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by %0t, required completion", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
